// File: rtl/mem_responder_if.sv
// Bus between the control unit (master) and the memory responder (slave).
// Carries the MOV/MOC handshake, the request fields from MAR/MDR and the
// read data returned to MDR.
// Optional build macro: MEM_MISALIGN_CHECK_EN adds the MISALIGN status line.
interface mem_responder_if #(
  parameter int ADDR_W = 8
);
  logic              MOV;
  logic              RW;
  logic [1:0]        DTYPE;
  logic [ADDR_W-1:0] ADDRESS;
  logic [31:0]       DATA_IN;
  logic [31:0]       DATA_OUT;
  logic              MOC;
`ifdef MEM_MISALIGN_CHECK_EN
  logic              MISALIGN;

  modport master (
    output MOV, RW, DTYPE, ADDRESS, DATA_IN,
    input  DATA_OUT, MOC, MISALIGN
  );

  modport slave (
    input  MOV, RW, DTYPE, ADDRESS, DATA_IN,
    output DATA_OUT, MOC, MISALIGN
  );
`else
  modport master (
    output MOV, RW, DTYPE, ADDRESS, DATA_IN,
    input  DATA_OUT, MOC
  );

  modport slave (
    input  MOV, RW, DTYPE, ADDRESS, DATA_IN,
    output DATA_OUT, MOC
  );
`endif
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder for the MOV/MOC handshake.
// Captures one request when MOV is seen high, waits WAIT_CYCLES, performs a
// big-endian byte/halfword/word access on an internal byte array, then holds
// MOC until MOV is released.
// Optional build macro: MEM_MISALIGN_CHECK_EN. When defined, unaligned
// halfword/word requests are not forced aligned: writes are dropped, reads
// return zero, and MISALIGN is raised alongside MOC.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  S_IDLE   | waiting for MOV; latches the request on the edge it is seen
//  S_WAIT   | counting down programmable wait states; inputs ignored
//  S_ACCESS | one cycle; array write or DATA_OUT load at its closing edge
//  S_DONE   | MOC held high until MOV is observed low
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  mem_responder_if.slave   bus
);

  localparam int         MEM_BYTES = 1 << ADDR_W;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [1:0]        dtype_q, dtype_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       data_out_q, data_out_d;
  logic              moc_q, moc_d;

  // Byte array; deliberately not cleared by reset.
  logic [7:0]        mem_q [0:MEM_BYTES-1];

  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] addr_p1, addr_p2, addr_p3;
  logic [31:0]       rd_data;
  logic              bad_align;
  logic              commit_wr;
  logic [3:0]        wr_en;
  logic [7:0]        wr_byte [0:3];
  logic [ADDR_W-1:0] wr_addr [0:3];

`ifdef MEM_MISALIGN_CHECK_EN
  logic              misalign_q, misalign_d;

  // Halfword needs bit 0 clear, word (and reserved) needs bits 1:0 clear.
  always_comb begin
    bad_align = 1'b0;
    if (dtype_q == 2'b01) begin
      bad_align = addr_q[0];
    end else if (dtype_q[1]) begin
      bad_align = (addr_q[1:0] != 2'b00);
    end
  end
`else
  assign bad_align = 1'b0;
`endif

  // Aligned base address of the latched request; alignment keeps every
  // access inside one aligned block, so base+3 never wraps past the top.
  always_comb begin
    base = addr_q;
    if (dtype_q == 2'b01) begin
      base = {addr_q[ADDR_W-1:1], 1'b0};
    end else if (dtype_q[1]) begin
      base = {addr_q[ADDR_W-1:2], 2'b00};
    end
    addr_p1 = base + ADDR_W'(1);
    addr_p2 = base + ADDR_W'(2);
    addr_p3 = base + ADDR_W'(3);
  end

  // Big-endian read assembly, zero-extended for byte and halfword.
  always_comb begin
    rd_data = {mem_q[base], mem_q[addr_p1], mem_q[addr_p2], mem_q[addr_p3]};
    if (dtype_q == 2'b00) begin
      rd_data = {24'h0, mem_q[base]};
    end else if (dtype_q == 2'b01) begin
      rd_data = {16'h0, mem_q[base], mem_q[addr_p1]};
    end
  end

  // Byte-lane write enables and data; the lowest address takes the MSB lane.
  always_comb begin
    commit_wr = (state_q == S_ACCESS) && !rw_q && !bad_align;
    wr_en      = 4'b0000;
    wr_addr[0] = base;
    wr_addr[1] = addr_p1;
    wr_addr[2] = addr_p2;
    wr_addr[3] = addr_p3;
    wr_byte[0] = wdata_q[31:24];
    wr_byte[1] = wdata_q[23:16];
    wr_byte[2] = wdata_q[15:8];
    wr_byte[3] = wdata_q[7:0];
    if (dtype_q == 2'b00) begin
      wr_en      = {3'b000, commit_wr};
      wr_byte[0] = wdata_q[7:0];
    end else if (dtype_q == 2'b01) begin
      wr_en      = {2'b00, commit_wr, commit_wr};
      wr_byte[0] = wdata_q[15:8];
      wr_byte[1] = wdata_q[7:0];
    end else begin
      wr_en      = {4{commit_wr}};
    end
  end

  // Array write port; only fires on the edge that ends ACCESS.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en[i]) begin
        mem_q[wr_addr[i]] <= wr_byte[i];
      end
    end
  end

  // Next-state and output logic for the handshake sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rw_d       = rw_q;
    dtype_d    = dtype_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    moc_d      = moc_q;
`ifdef MEM_MISALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.MOV) begin
          rw_d    = bus.RW;
          dtype_d = bus.DTYPE;
          addr_d  = bus.ADDRESS;
          wdata_d = bus.DATA_IN;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_INIT == 4'd0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // The edge that takes the counter to zero also enters ACCESS.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (rw_q) begin
          data_out_d = bad_align ? 32'h0000_0000 : rd_data;
        end
        moc_d   = 1'b1;
`ifdef MEM_MISALIGN_CHECK_EN
        misalign_d = bad_align;
`endif
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!bus.MOV) begin
          moc_d   = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
          misalign_d = 1'b0;
`endif
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and request registers; reset aborts any in-flight request.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      rw_q       <= 1'b0;
      dtype_q    <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      data_out_q <= 32'h0;
      moc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rw_q       <= rw_d;
      dtype_q    <= dtype_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
      moc_q      <= moc_d;
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  // Misalignment flag shares the MOC lifetime.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign bus.MISALIGN = misalign_q;
`endif

  assign bus.DATA_OUT = data_out_q;
  assign bus.MOC      = moc_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: the driver issues requests and pushes
// the expected completion into a queue; the monitor pops on each MOC rise.
module tb_mem_responder;
  localparam int ADDR_W = 8;
  localparam int WAIT   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_W(ADDR_W)) mif ();

  mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT)) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (mif.slave)
  );

  typedef struct {
    logic [31:0] data;
    int          cyc;
    logic        mis;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          passed = 0;
  int          cycle  = 0;
  logic        mov_smp = 1'b0;
  logic [7:0]  model_mem [256];
  logic [31:0] last_read = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_bound(input string name);
    checks++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Reference model: a plain byte array with big-endian sized accesses.
  task automatic model_op(input logic rw, input logic [1:0] dt, input logic [7:0] a,
                          input logic [31:0] d, output logic [31:0] exp_out,
                          output logic exp_mis);
    int n, off, base;
    logic [31:0] v;
    n    = (dt == 2'b00) ? 1 : (dt == 2'b01) ? 2 : 4;
    off  = int'(a) % n;
    base = int'(a) - off;
    exp_mis = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    if (off != 0) begin
      exp_mis = 1'b1;
      if (rw) last_read = 32'h0;
      exp_out = last_read;
      return;
    end
`endif
    if (rw) begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(model_mem[base + i]);
      last_read = v;
    end else begin
      for (int i = 0; i < n; i++) model_mem[base + i] = 8'((d >> (8 * (n - 1 - i))) & 32'hFF);
    end
    exp_out = last_read;
  endtask

  task automatic scramble();
    mif.RW      = 1'($urandom);
    mif.DTYPE   = 2'($urandom);
    mif.ADDRESS = 8'($urandom);
    mif.DATA_IN = $urandom;
  endtask

  task automatic do_op(input logic rw, input logic [1:0] dt, input logic [7:0] a,
                       input logic [31:0] d, input bit drop_early);
    exp_t e;
    int n;
    @(negedge clk);
    model_op(rw, dt, a, d, e.data, e.mis);
    e.cyc = cycle + WAIT + 2;
    sb_q.push_back(e);
    mif.MOV = 1'b1; mif.RW = rw; mif.DTYPE = dt; mif.ADDRESS = a; mif.DATA_IN = d;
    if (drop_early) begin
      @(negedge clk);
      mif.MOV = 1'b0;
      scramble();
    end
    n = 0;
    while (!mif.MOC && n < 20) begin
      @(negedge clk);
      scramble();
      n++;
    end
    if (!mif.MOC) begin
      fail_bound("moc_rise_timeout");
      mif.MOV = 1'b0;
      return;
    end
    if (!drop_early) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      mif.MOV = 1'b0;
    end
    n = 0;
    while (mif.MOC && n < 5) begin
      @(negedge clk);
      n++;
    end
    if (mif.MOC) fail_bound("moc_fall_timeout");
  endtask

  always @(posedge clk) begin
    cycle++;
    mov_smp = mif.MOV;
  end

  // Monitor: completion checks on MOC rise, hold/release checks while high.
  initial begin : monitor
    logic moc_prev;
    exp_t cur;
    moc_prev = 1'b0;
    cur.data = 32'h0; cur.cyc = 0; cur.mis = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        moc_prev = 1'b0;
      end else begin
        if (mif.MOC && !moc_prev) begin
          if (sb_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_moc: got MOC=1 required no completion (t=%0t)", $time);
          end else begin
            cur = sb_q.pop_front();
            check("latency_cycle", 32'(cycle), 32'(cur.cyc));
            check("data_out", mif.DATA_OUT, cur.data);
`ifdef MEM_MISALIGN_CHECK_EN
            check("misalign", 32'(mif.MISALIGN), 32'(cur.mis));
`endif
          end
        end else if (moc_prev) begin
          check("moc_follows_mov", 32'(mif.MOC), 32'(mov_smp));
          check("data_out_hold", mif.DATA_OUT, cur.data);
`ifdef MEM_MISALIGN_CHECK_EN
          check("misalign_hold", 32'(mif.MISALIGN), mif.MOC ? 32'(cur.mis) : 32'h0);
`endif
        end
        moc_prev = mif.MOC;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [31:0] v;
    mif.MOV = 1'b0; mif.RW = 1'b0; mif.DTYPE = 2'b00; mif.ADDRESS = '0; mif.DATA_IN = 32'h0;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;

    // Reset then idle.
    repeat (2) begin
      @(negedge clk);
      check("reset_moc", 32'(mif.MOC), 32'h0);
      check("reset_data_out", mif.DATA_OUT, 32'h0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_moc", 32'(mif.MOC), 32'h0);
      check("idle_data_out", mif.DATA_OUT, 32'h0);
    end

    // Fill the whole array so every later read has defined contents.
    for (int a = 0; a < 256; a += 4) do_op(1'b0, 2'b10, 8'(a), $urandom, 1'b0);

    // Word write/read at 0x10, byte read at 0x12.
    do_op(1'b0, 2'b10, 8'h10, 32'hA1B2C3D4, 1'b0);
    do_op(1'b1, 2'b10, 8'h10, 32'h0, 1'b0);
    check("plan_word_read", mif.DATA_OUT, 32'hA1B2C3D4);
    do_op(1'b1, 2'b00, 8'h12, 32'h0, 1'b0);
    check("plan_byte_read", mif.DATA_OUT, 32'h0000_00C3);

    // Halfword write at 0x21 lands on 0x20; low half keeps prior value.
    v = {model_mem[8'h22], model_mem[8'h23], 16'h0};
    do_op(1'b0, 2'b01, 8'h21, 32'hFFFF_55AA, 1'b0);
    do_op(1'b1, 2'b10, 8'h20, 32'h0, 1'b0);
    check("plan_half_upper", {16'h0, mif.DATA_OUT[31:16]}, 32'h0000_55AA);
    check("plan_half_lower", {16'h0, mif.DATA_OUT[15:0]}, {16'h0, v[31:16]});

    // MOV dropped during WAIT on a read.
    do_op(1'b1, 2'b10, 8'h10, 32'h0, 1'b1);

    // Reset mid-operation aborts the write.
    @(negedge clk);
    mif.MOV = 1'b1; mif.RW = 1'b0; mif.DTYPE = 2'b10; mif.ADDRESS = 8'h40; mif.DATA_IN = 32'hDEADBEEF;
    @(negedge clk);
    mif.MOV = 1'b0;
    rst_n = 1'b0;
    last_read = 32'h0;
    @(negedge clk);
    check("midop_reset_moc", 32'(mif.MOC), 32'h0);
    check("midop_reset_data_out", mif.DATA_OUT, 32'h0);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("post_reset_moc", 32'(mif.MOC), 32'h0);
    end
    do_op(1'b1, 2'b10, 8'h40, 32'h0, 1'b0);

    // Unaligned word write/read at 0x43 (aligned to 0x40 unless checked).
    do_op(1'b0, 2'b10, 8'h43, 32'h1234_5678, 1'b0);
    do_op(1'b1, 2'b10, 8'h43, 32'h0, 1'b0);
    do_op(1'b1, 2'b10, 8'h40, 32'h0, 1'b0);

    // Randomized traffic, including reserved DTYPE and early MOV drops.
    for (int i = 0; i < 150; i++) begin
      do_op(1'($urandom), 2'($urandom), 8'($urandom), $urandom, ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the control unit's MOV/MOC handshake.
- Captures one request when MOV rises: address, R/W, data type and write data.
- Inserts programmable wait states, then performs a big-endian byte/halfword/word access on an internal byte array.
- Asserts MOC and holds it until MOV is released.
- Sits between the datapath MAR/MDR and the control unit's MOC condition input.

Parameters:
- ADDR_W, 8, byte-address width; the array holds 2^ADDR_W bytes.
- WAIT_CYCLES, 2, wait states inserted before the access commits; legal range 0..15.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- MOV  in  1  memory operation valid, level-held by the control unit.
- RW  in  1  1 = read, 0 = write.
- DTYPE  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- ADDRESS  in  ADDR_W  byte address from MAR.
- DATA_IN  in  32  write data from MDR.
- DATA_OUT  out  32  read data to MDR.
- MOC  out  1  memory operation complete.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - MOC=0, DATA_OUT=0, state=IDLE, wait counter=0.
  - Array contents are not cleared.
  - A reset arriving before the commit edge aborts the operation: no write occurs.
- States: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - On an edge with MOV=1, latch RW, DTYPE, ADDRESS and DATA_IN into request registers.
  - Load counter=WAIT_CYCLES.
  - Next state is WAIT, or ACCESS directly if WAIT_CYCLES=0.
- WAIT:
  - Counter decrements each edge.
  - Leave for ACCESS on the edge where the counter reaches 0.
  - Input changes during WAIT are ignored; only the latched request is used.
- ACCESS (one cycle), acted on at the edge that ends it:
  - Write: commit the bytes to the array.
  - Read: load DATA_OUT.
  - Set MOC=1 and go to DONE.
- Latency: if MOV is sampled high at edge k, MOC is high after edge k+WAIT_CYCLES+1 (k+3 at default).
- DONE:
  - MOC=1; DATA_OUT holds its value.
  - On the first edge with MOV=0: MOC=0 and state=IDLE.
  - A new request is accepted no earlier than the edge after MOC falls, so MOV must be observed low for at least one cycle between operations.
  - If MOV was already low at DONE entry, MOC is high for exactly one cycle.
- Addressing (big-endian): byte at A = mem[A].
  - Halfword: ADDRESS[0] is forced to 0; mem[A]=bits 15:8, mem[A+1]=bits 7:0.
  - Word: ADDRESS[1:0] are forced to 0; mem[A]=bits 31:24 through mem[A+3]=bits 7:0.
  - Because of forced alignment, no access wraps past the top of the array.
- Read data:
  - Byte and halfword reads are zero-extended in DATA_OUT.
  - Write operations leave DATA_OUT unchanged.
- Write data: byte writes use DATA_IN[7:0]; halfword writes use DATA_IN[15:0]; no other bytes are touched.
- MOV deasserted during WAIT: the operation still completes; MOC pulses for one cycle (see DONE).

Optional Feature:
- Macro: MEM_MISALIGN_CHECK_EN.
- When defined:
  - Adds output MISALIGN (1 bit, reset 0).
  - A halfword request with ADDRESS[0]=1, or a word request with ADDRESS[1:0]!=0, is not forced aligned.
  - The write is suppressed, and a read returns 32'h0000_0000.
  - MISALIGN=1 in DONE alongside MOC and clears together with MOC.
  - Handshake timing is unchanged.
- When undefined: no MISALIGN port; low address bits are silently forced to zero as above.

Test Plan:
- Reset then idle: RST_N low for 2 cycles, MOV=0 -> MOC=0 and DATA_OUT=0 throughout, with no state change.
- Word write then read at 0x10: write DATA_IN=32'hA1B2C3D4; MOC rises exactly 3 edges after MOV sampled, falls one edge after MOV drops. Then read word 0x10 -> DATA_OUT=32'hA1B2C3D4; byte read 0x12 -> 32'h000000C3.
- Halfword write 16'h55AA at 0x21 (forced to 0x20), then word read 0x20 -> upper halfword 55AA, lower halfword unchanged from its prior value.
- MOV dropped during WAIT on a read -> MOC high for exactly one cycle, and DATA_OUT carries the read value.
- Reset mid-op: word write of 32'hDEADBEEF to 0x40, RST_N pulsed low in WAIT -> later read of 0x40 returns the old contents, and MOC stays 0 until a new request.
- With MEM_MISALIGN_CHECK_EN: word write to 0x43 -> MISALIGN=1 with MOC and no array change; read of 0x43 returns 0.
